// File: rtl/led_seq_pkg.sv
// Shared types and default widths for the LED pattern address sequencer.
package led_seq_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 4;
    localparam int unsigned DIV_W_DEFAULT  = 24;

    typedef enum logic [1:0] {
        ModeUp   = 2'b00,
        ModeDown = 2'b01,
        ModePing = 2'b10,
        ModeOnce = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_t;

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: counts 0..div_i while enabled and flags a step on the
// cycle the count reaches div_i, reloading to zero on the same edge.
module led_step_prescaler #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             step_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign step_o = en_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives the LED pattern memory address through a latched [start,end] window
// in one of four walk modes, advancing once per prescaler step.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DIV_W  = DIV_W_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              enable_i,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    input  logic [DIV_W-1:0]  div_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              active_o,
    output logic              done_o,
    output logic              wrap_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              dir_down_q, dir_down_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic              load;
    logic              clr;
    logic              step;

    led_step_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .sys_clk (sys_clk),
        .reset   (reset),
        .en_i    ((state_q == StRun) && enable_i),
        .clr_i   (clr),
        .div_i   (div_q),
        .step_o  (step)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        div_d      = div_q;
        dir_down_d = dir_down_q;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        load       = 1'b0;
        clr        = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if (start_i) begin
                    load = 1'b1;
                end
            end
            StRun: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if (step) begin
                    case (mode_q)
                        ModeUp: begin
                            if (addr_q == hi_q) begin
                                addr_d = lo_q;
                                wrap_d = 1'b1;
                            end else begin
                                addr_d = addr_q + AddrOne;
                            end
                        end
                        ModeDown: begin
                            if (addr_q == lo_q) begin
                                addr_d = hi_q;
                                wrap_d = 1'b1;
                            end else begin
                                addr_d = addr_q - AddrOne;
                            end
                        end
                        ModePing: begin
                            // A one-word window has no turnaround, so every step counts as a period.
                            if (lo_q == hi_q) begin
                                wrap_d = 1'b1;
                            end else if (!dir_down_q && addr_q == hi_q) begin
                                dir_down_d = 1'b1;
                                addr_d     = hi_q - AddrOne;
                            end else if (dir_down_q && addr_q == lo_q) begin
                                dir_down_d = 1'b0;
                                addr_d     = lo_q + AddrOne;
                                wrap_d     = 1'b1;
                            end else if (dir_down_q) begin
                                addr_d = addr_q - AddrOne;
                            end else begin
                                addr_d = addr_q + AddrOne;
                            end
                        end
                        default: begin
                            if (addr_q == hi_q) begin
                                state_d = StDone;
                                wrap_d  = 1'b1;
                            end else begin
                                addr_d = addr_q + AddrOne;
                            end
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            if (start_addr_i <= end_addr_i) begin
                state_d    = StRun;
                mode_d     = mode_t'(mode_i);
                lo_d       = start_addr_i;
                hi_d       = end_addr_i;
                div_d      = div_i;
                dir_down_d = 1'b0;
                clr        = 1'b1;
                addr_d     = (mode_t'(mode_i) == ModeDown) ? end_addr_i : start_addr_i;
            end else begin
                err_d = 1'b1;
            end
        end

        active_d = (state_d == StRun);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            mode_q     <= ModeUp;
            addr_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            div_q      <= '0;
            dir_down_q <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            div_q      <= div_d;
            dir_down_q <= dir_down_d;
            active_q   <= active_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    assign addr_o   = addr_q;
    assign active_o = active_q;
    assign done_o   = done_q;
    assign wrap_o   = wrap_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scenario bench for led_pattern_sequencer: expected per-cycle outputs are
// queued from the walk definitions and drained against the DUT each cycle.
module tb_led_pattern_sequencer;

    localparam int AW = 4;
    localparam int DW = 24;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          enable_i = 1'b1;
    logic [1:0]    mode_i = 2'b00;
    logic [AW-1:0] start_addr_i = '0;
    logic [AW-1:0] end_addr_i = '0;
    logic [DW-1:0] div_i = '0;
    logic [AW-1:0] addr_o;
    logic          active_o;
    logic          done_o;
    logic          wrap_o;
    logic          err_o;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wrap;
        logic          active;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    led_pattern_sequencer #(
        .ADDR_W (AW),
        .DIV_W  (DW)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .div_i        (div_i),
        .addr_o       (addr_o),
        .active_o     (active_o),
        .done_o       (done_o),
        .wrap_o       (wrap_o),
        .err_o        (err_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic w, input logic act,
                            input logic dn, input int reps);
        for (int k = 0; k < reps; k++) sb.push_back('{a, w, act, dn});
    endtask

    // Pulses start with the given config, then scrambles config to show it is not resampled.
    task automatic launch(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input logic [DW-1:0] d);
        mode_i = m; start_addr_i = s; end_addr_i = e; div_i = d;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        mode_i = ~m; start_addr_i = ~s; end_addr_i = ~e; div_i = d + 24'd5;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (addr_o !== 4'd0 || active_o !== 1'b0 || done_o !== 1'b0 || wrap_o !== 1'b0
            || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: addr=%0d act=%b done=%b wrap=%b err=%b, expected all 0",
                     addr_o, active_o, done_o, wrap_o, err_o);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_up();
        exp_t e;
        int   i = 0;
        push_exp(4'd2, 1'b0, 1'b1, 1'b0, 4);
        push_exp(4'd3, 1'b0, 1'b1, 1'b0, 4);
        push_exp(4'd4, 1'b0, 1'b1, 1'b0, 4);
        push_exp(4'd5, 1'b0, 1'b1, 1'b0, 4);
        push_exp(4'd2, 1'b1, 1'b1, 1'b0, 1);
        launch(2'b00, 4'd2, 4'd5, 24'd3);
        while (sb.size() > 0) begin
            start_addr_i = 4'd0; end_addr_i = 4'd1; mode_i = 2'b01;
            start_i = (i == 5);  // restart attempt while running must be ignored
            e = sb.pop_front();
            checks++;
            if (addr_o !== e.addr || wrap_o !== e.wrap || active_o !== e.active
                || done_o !== e.done) begin
                errors++;
                $display("FAIL up_seq[%0d]: addr=%0d wrap=%b act=%b done=%b, expected addr=%0d wrap=%b act=%b done=%b",
                         i, addr_o, wrap_o, active_o, done_o, e.addr, e.wrap, e.active, e.done);
            end
            tick();
            i++;
        end
        start_i = 1'b0;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if (addr_o !== 4'd2 || active_o !== 1'b0) begin
            errors++;
            $display("FAIL up_stop: addr=%0d act=%b, expected addr=2 act=0", addr_o, active_o);
        end
    endtask

    task automatic test_down();
        exp_t e;
        int   i = 0;
        push_exp(4'd3, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd2, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd1, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd0, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd3, 1'b1, 1'b1, 1'b0, 1);
        launch(2'b01, 4'd0, 4'd3, 24'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (addr_o !== e.addr || wrap_o !== e.wrap || active_o !== e.active
                || done_o !== e.done) begin
                errors++;
                $display("FAIL down_seq[%0d]: addr=%0d wrap=%b act=%b done=%b, expected addr=%0d wrap=%b act=%b done=%b",
                         i, addr_o, wrap_o, active_o, done_o, e.addr, e.wrap, e.active, e.done);
            end
            tick();
            i++;
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if (addr_o !== 4'd2 || active_o !== 1'b0) begin
            errors++;
            $display("FAIL down_stop: addr=%0d act=%b, expected addr=2 act=0", addr_o, active_o);
        end
    endtask

    task automatic test_ping();
        exp_t e;
        int   i = 0;
        push_exp(4'd1, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd2, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd3, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd2, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd1, 1'b0, 1'b1, 1'b0, 1);
        push_exp(4'd2, 1'b1, 1'b1, 1'b0, 1);
        push_exp(4'd3, 1'b0, 1'b1, 1'b0, 1);
        launch(2'b10, 4'd1, 4'd3, 24'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (addr_o !== e.addr || wrap_o !== e.wrap || active_o !== e.active
                || done_o !== e.done) begin
                errors++;
                $display("FAIL ping_seq[%0d]: addr=%0d wrap=%b act=%b done=%b, expected addr=%0d wrap=%b act=%b done=%b",
                         i, addr_o, wrap_o, active_o, done_o, e.addr, e.wrap, e.active, e.done);
            end
            tick();
            i++;
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if (addr_o !== 4'd2 || active_o !== 1'b0) begin
            errors++;
            $display("FAIL ping_stop: addr=%0d act=%b, expected addr=2 act=0", addr_o, active_o);
        end
    endtask

    task automatic test_once();
        exp_t e;
        int   i = 0;
        push_exp(4'd6, 1'b0, 1'b1, 1'b0, 2);
        push_exp(4'd7, 1'b0, 1'b1, 1'b0, 2);
        push_exp(4'd8, 1'b0, 1'b1, 1'b0, 2);
        push_exp(4'd8, 1'b1, 1'b0, 1'b1, 1);
        push_exp(4'd8, 1'b0, 1'b0, 1'b1, 3);
        launch(2'b11, 4'd6, 4'd8, 24'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (addr_o !== e.addr || wrap_o !== e.wrap || active_o !== e.active
                || done_o !== e.done) begin
                errors++;
                $display("FAIL once_seq[%0d]: addr=%0d wrap=%b act=%b done=%b, expected addr=%0d wrap=%b act=%b done=%b",
                         i, addr_o, wrap_o, active_o, done_o, e.addr, e.wrap, e.active, e.done);
            end
            tick();
            i++;
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if (addr_o !== 4'd8 || done_o !== 1'b0 || active_o !== 1'b0) begin
            errors++;
            $display("FAIL once_stop: addr=%0d done=%b act=%b, expected addr=8 done=0 act=0",
                     addr_o, done_o, active_o);
        end
    endtask

    task automatic test_bad_config();
        launch(2'b00, 4'd9, 4'd4, 24'd0);
        checks++;
        if (err_o !== 1'b1 || active_o !== 1'b0 || addr_o !== 4'd8) begin
            errors++;
            $display("FAIL err_pulse: err=%b act=%b addr=%0d, expected err=1 act=0 addr=8",
                     err_o, active_o, addr_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0 || active_o !== 1'b0 || addr_o !== 4'd8) begin
            errors++;
            $display("FAIL err_clear: err=%b act=%b addr=%0d, expected err=0 act=0 addr=8",
                     err_o, active_o, addr_o);
        end
    endtask

    task automatic test_enable_freeze();
        exp_t e;
        int   i = 0;
        push_exp(4'd3, 1'b0, 1'b1, 1'b0, 13);
        push_exp(4'd4, 1'b0, 1'b1, 1'b0, 3);
        push_exp(4'd5, 1'b0, 1'b1, 1'b0, 1);
        launch(2'b00, 4'd3, 4'd7, 24'd2);
        while (sb.size() > 0) begin
            if (i == 1) enable_i = 1'b0;
            if (i == 11) enable_i = 1'b1;
            e = sb.pop_front();
            checks++;
            if (addr_o !== e.addr || wrap_o !== e.wrap || active_o !== e.active
                || done_o !== e.done) begin
                errors++;
                $display("FAIL enable_seq[%0d]: addr=%0d wrap=%b act=%b done=%b, expected addr=%0d wrap=%b act=%b done=%b",
                         i, addr_o, wrap_o, active_o, done_o, e.addr, e.wrap, e.active, e.done);
            end
            tick();
            i++;
        end
        mode_i = 2'b01; start_addr_i = 4'd10; end_addr_i = 4'd12;
        start_i = 1'b1;
        stop_i = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i = 1'b0;
        checks++;
        if (active_o !== 1'b0 || addr_o !== 4'd5) begin
            errors++;
            $display("FAIL start_stop_same: act=%b addr=%0d, expected act=0 addr=5",
                     active_o, addr_o);
        end
        tick();
        checks++;
        if (active_o !== 1'b0 || addr_o !== 4'd5) begin
            errors++;
            $display("FAIL start_stop_idle: act=%b addr=%0d, expected act=0 addr=5",
                     active_o, addr_o);
        end
    endtask

    task automatic test_reset_mid_run();
        launch(2'b00, 4'd3, 4'd7, 24'd0);
        tick();
        tick();
        checks++;
        if (addr_o !== 4'd5 || active_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_run: addr=%0d act=%b, expected addr=5 act=1", addr_o, active_o);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (addr_o !== 4'd0 || active_o !== 1'b0 || wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: addr=%0d act=%b wrap=%b, expected addr=0 act=0 wrap=0",
                     addr_o, active_o, wrap_o);
        end
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (addr_o !== 4'd0 || active_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: addr=%0d act=%b, expected addr=0 act=0",
                     addr_o, active_o);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_up();
        test_down();
        test_ping();
        test_once();
        test_bad_config();
        test_enable_freeze();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
